// File: rtl/zbt_frame_reader_pkg.sv
// Shared widths, raster defaults, swap-FSM state type and the frame-buffer address map.
package zbt_frame_reader_pkg;
  localparam int LOG_ADDR     = 19;
  localparam int LOG_MEM      = 36;
  localparam int PIX_W        = 18;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

  typedef enum logic {
    SW_IDLE,
    SW_PENDING
  } swap_state_e;

  // Each buffer starts 128K words apart; inside a buffer the address is {y, x}.
  function automatic logic [LOG_ADDR-1:0] calc_addr(input logic [9:0] x,
                                                    input logic [8:0] y,
                                                    input logic [1:0] loc);
    return {y, x} + {loc, 17'd0};
  endfunction
endpackage

// File: rtl/zbt_frame_reader_if.sv
// Raster, swap handshake and ZBT bus signals between the display parent and the frame reader.
interface zbt_frame_reader_if;
  import zbt_frame_reader_pkg::*;

  logic [10:0]         hcount;
  logic [9:0]          vcount;
  logic                swap_req;
  logic [1:0]          swap_loc;
  logic [LOG_MEM-1:0]  mem_read_data;
  logic [LOG_ADDR-1:0] mem_addr;
  logic                mem_wr;
  logic [PIX_W-1:0]    pixel;
  logic                pixel_valid;
  logic [1:0]          display_loc;
  logic                swap_ack;

  modport master (
    output hcount, vcount, swap_req, swap_loc, mem_read_data,
    input  mem_addr, mem_wr, pixel, pixel_valid, display_loc, swap_ack
  );

  modport slave (
    input  hcount, vcount, swap_req, swap_loc, mem_read_data,
    output mem_addr, mem_wr, pixel, pixel_valid, display_loc, swap_ack
  );
endinterface

// File: rtl/zbt_frame_reader_addr_calc.sv
// address_calculator: maps a raster (x, y) in buffer loc to its ZBT word address.
module zbt_frame_reader_addr_calc
  import zbt_frame_reader_pkg::*;
(
  input  logic [9:0]          i_x,
  input  logic [8:0]          i_y,
  input  logic [1:0]          i_loc,
  output logic [LOG_ADDR-1:0] o_addr
);
  assign o_addr = calc_addr(i_x, i_y, i_loc);
endmodule

// File: rtl/zbt_frame_reader.sv
// Raster-driven ZBT reader with fixed MEM_LATENCY+2 pixel latency and tear-free buffer swap.
// state      | meaning
// SW_IDLE    | no swap outstanding, display_loc stable
// SW_PENDING | next_loc holds a completed buffer, applied at the next vblank start
module zbt_frame_reader
  import zbt_frame_reader_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int MEM_LATENCY = 2
) (
  input logic               i_clock,
  input logic               i_reset,
  zbt_frame_reader_if.slave bus
);
  localparam int          DEPTH = MEM_LATENCY + 2;
  localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
  localparam logic [9:0]  V_LIM = 10'(V_ACTIVE);

  logic                w_active;
  logic                w_vblank_start;
  logic [LOG_ADDR-1:0] w_addr;
  logic                w_unused;
  logic [LOG_ADDR-1:0] r_mem_addr;
  logic [DEPTH-1:0]    r_act_d;
  logic [PIX_W-1:0]    r_pixel;
  swap_state_e         r_state;
  swap_state_e         w_state_nxt;
  logic [1:0]          r_next_loc;
  logic [1:0]          w_next_loc_nxt;
  logic [1:0]          r_display_loc;
  logic [1:0]          w_display_loc_nxt;
  logic                r_swap_ack;
  logic                w_swap_ack_nxt;

  assign w_active       = (bus.hcount < H_LIM) && (bus.vcount < V_LIM);
  assign w_vblank_start = (bus.hcount == 11'd0) && (bus.vcount == V_LIM);
  assign w_unused       = ^bus.mem_read_data[LOG_MEM-PIX_W-1:0];

  zbt_frame_reader_addr_calc u_addr_calc (
    .i_x    (bus.hcount[9:0]),
    .i_y    (bus.vcount[8:0]),
    .i_loc  (r_display_loc),
    .o_addr (w_addr)
  );

  // act_d[MEM_LATENCY] lines up with the returning read; its next stage is pixel_valid.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_mem_addr <= '0;
      r_act_d    <= '0;
      r_pixel    <= '0;
    end else begin
      r_mem_addr <= w_active ? w_addr : '0;
      r_act_d    <= {r_act_d[DEPTH-2:0], w_active};
      r_pixel    <= r_act_d[MEM_LATENCY] ? bus.mem_read_data[LOG_MEM-1:LOG_MEM-PIX_W] : '0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state       <= SW_IDLE;
      r_next_loc    <= 2'd0;
      r_display_loc <= 2'd0;
      r_swap_ack    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_next_loc    <= w_next_loc_nxt;
      r_display_loc <= w_display_loc_nxt;
      r_swap_ack    <= w_swap_ack_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_next_loc_nxt    = r_next_loc;
    w_display_loc_nxt = r_display_loc;
    w_swap_ack_nxt    = 1'b0;
    case (r_state)
      SW_IDLE: begin
        if (bus.swap_req) begin
          w_next_loc_nxt = bus.swap_loc;
          w_state_nxt    = SW_PENDING;
        end
      end
      SW_PENDING: begin
        if (w_vblank_start) begin
          w_display_loc_nxt = r_next_loc;
          w_swap_ack_nxt    = 1'b1;
          w_state_nxt       = SW_IDLE;
        end
        // A request on the swap cycle itself is queued for the following frame.
        if (bus.swap_req) begin
          w_next_loc_nxt = bus.swap_loc;
          w_state_nxt    = SW_PENDING;
        end
      end
      default: w_state_nxt = SW_IDLE;
    endcase
  end

  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wr      = 1'b0;
  assign bus.pixel       = r_pixel;
  assign bus.pixel_valid = r_act_d[DEPTH-1];
  assign bus.display_loc = r_display_loc;
  assign bus.swap_ack    = r_swap_ack;
endmodule

// File: tb/tb_zbt_frame_reader.sv
// Directed bench for zbt_frame_reader on a reduced 32x24 raster (40x30 total) with an echoing ZBT model.
module tb_zbt_frame_reader;
  localparam int H_ACT = 32;
  localparam int V_ACT = 24;
  localparam int H_TOT = 40;
  localparam int V_TOT = 30;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int VB    = V_ACT * H_TOT;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   ack_cnt;
  int   ack_j;
  int   chg_j;
  logic [18:0] mem_d1;

  zbt_frame_reader_if bus ();

  zbt_frame_reader #(.H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .MEM_LATENCY(2)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ZBT model: address registered at edge 1, echo data valid after edge 3.
  always @(posedge clk) begin
    mem_d1            <= bus.mem_addr;
    bus.mem_read_data <= {mem_d1[17:0], 18'd0};
  end

  function automatic logic [18:0] exp_addr(input int h, input int v, input int loc);
    logic [18:0] a;
    if (h < H_ACT && v < V_ACT) a = 19'(v * 1024 + h + loc * 131072);
    else a = 19'd0;
    return a;
  endfunction

  task automatic step(input int h, input int v, input logic rq, input logic [1:0] lc);
    bus.hcount   = 11'(h);
    bus.vcount   = 10'(v);
    bus.swap_req = rq;
    bus.swap_loc = lc;
    @(posedge clk);
    #1;
  endtask

  task automatic run_raster(input int n, input int rq0, input logic [1:0] l0,
                            input int rq1, input logic [1:0] l1);
    logic [1:0] start_loc;
    start_loc = bus.display_loc;
    ack_cnt = 0;
    ack_j   = -1;
    chg_j   = -1;
    for (int j = 0; j < n; j++) begin
      step(j % H_TOT, (j / H_TOT) % V_TOT, (j == rq0) || (j == rq1), (j == rq1) ? l1 : l0);
      if (bus.swap_ack) begin
        ack_cnt++;
        if (ack_j < 0) ack_j = j;
      end
      if (chg_j < 0 && bus.display_loc != start_loc) chg_j = j;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(H_TOT - 1, V_TOT - 1, 1'b0, 2'd0);
    step(H_TOT - 1, V_TOT - 1, 1'b0, 2'd0);
    total++; if (bus.mem_addr !== 19'd0) begin bad++; $display("FAIL reset_mem_addr got=%h want=0", bus.mem_addr); end
    total++; if (bus.mem_wr !== 1'b0) begin bad++; $display("FAIL reset_mem_wr got=%b want=0", bus.mem_wr); end
    total++; if (bus.pixel !== 18'd0) begin bad++; $display("FAIL reset_pixel got=%h want=0", bus.pixel); end
    total++; if (bus.pixel_valid !== 1'b0) begin bad++; $display("FAIL reset_pixel_valid got=%b want=0", bus.pixel_valid); end
    total++; if (bus.display_loc !== 2'd0) begin bad++; $display("FAIL reset_display_loc got=%0d want=0", bus.display_loc); end
    total++; if (bus.swap_ack !== 1'b0) begin bad++; $display("FAIL reset_swap_ack got=%b want=0", bus.swap_ack); end
    rst_n = 1'b1;
  endtask

  task automatic test_full_frame();
    int nvalid = 0;
    int rise = -1;
    int ph, pv;
    logic ev;
    logic [18:0] ea;
    logic [17:0] ep;
    for (int j = 0; j < FRAME + 3; j++) begin
      step(j % H_TOT, (j / H_TOT) % V_TOT, 1'b0, 2'd0);
      ea = exp_addr(j % H_TOT, (j / H_TOT) % V_TOT, 0);
      total++;
      if (bus.mem_addr !== ea) begin
        bad++; $display("FAIL frame_addr j=%0d got=%h want=%h", j, bus.mem_addr, ea);
      end
      ev = 1'b0;
      ep = 18'd0;
      if (j >= 3) begin
        ph = (j - 3) % H_TOT;
        pv = ((j - 3) / H_TOT) % V_TOT;
        ev = (ph < H_ACT) && (pv < V_ACT);
        ea = exp_addr(ph, pv, 0);
        ep = ea[17:0];
      end
      total++;
      if (bus.pixel_valid !== ev || bus.pixel !== ep) begin
        bad++; $display("FAIL frame_pixel j=%0d got=%b/%h want=%b/%h", j, bus.pixel_valid, bus.pixel, ev, ep);
      end
      if (bus.pixel_valid) begin
        nvalid++;
        if (rise < 0) rise = j;
      end
    end
    total++; if (rise != 3) begin bad++; $display("FAIL first_valid_step got=%0d want=3", rise); end
    total++; if (nvalid != H_ACT * V_ACT) begin bad++; $display("FAIL valid_count got=%0d want=%0d", nvalid, H_ACT * V_ACT); end
    total++; if (bus.display_loc !== 2'd0) begin bad++; $display("FAIL frame_loc got=%0d want=0", bus.display_loc); end
  endtask

  task automatic test_blanking();
    step(5, 3, 1'b0, 2'd0);
    step(700, 100, 1'b0, 2'd0);
    total++; if (bus.mem_addr !== 19'd0) begin bad++; $display("FAIL blank_mem_addr got=%h want=0", bus.mem_addr); end
    step(700, 100, 1'b0, 2'd0);
    step(700, 100, 1'b0, 2'd0);
    total++;
    if (bus.pixel_valid !== 1'b1 || bus.pixel !== 18'd3077) begin
      bad++; $display("FAIL blank_prev_pixel got=%b/%h want=1/%h", bus.pixel_valid, bus.pixel, 18'd3077);
    end
    step(700, 100, 1'b0, 2'd0);
    total++;
    if (bus.pixel_valid !== 1'b0 || bus.pixel !== 18'd0) begin
      bad++; $display("FAIL blank_pixel got=%b/%h want=0/0", bus.pixel_valid, bus.pixel);
    end
  endtask

  task automatic test_swap();
    run_raster(FRAME + 1, 10 * H_TOT + 5, 2'd1, -1, 2'd0);
    total++; if (ack_cnt != 1) begin bad++; $display("FAIL swap_ack_count got=%0d want=1", ack_cnt); end
    total++; if (ack_j != VB) begin bad++; $display("FAIL swap_ack_step got=%0d want=%0d", ack_j, VB); end
    total++; if (chg_j != VB) begin bad++; $display("FAIL swap_loc_step got=%0d want=%0d", chg_j, VB); end
    total++; if (bus.display_loc !== 2'd1) begin bad++; $display("FAIL swap_loc got=%0d want=1", bus.display_loc); end
    total++; if (bus.mem_addr !== 19'h20000) begin bad++; $display("FAIL swap_addr00 got=%h want=20000", bus.mem_addr); end
    step(1, 0, 1'b0, 2'd0);
    step(2, 0, 1'b0, 2'd0);
    step(3, 0, 1'b0, 2'd0);
    total++;
    if (bus.pixel_valid !== 1'b1 || bus.pixel !== 18'h20000) begin
      bad++; $display("FAIL swap_pixel00 got=%b/%h want=1/20000", bus.pixel_valid, bus.pixel);
    end
  endtask

  task automatic test_two_requests();
    run_raster(FRAME + 1, 100, 2'd1, 500, 2'd2);
    total++; if (ack_cnt != 1) begin bad++; $display("FAIL two_req_ack_count got=%0d want=1", ack_cnt); end
    total++; if (ack_j != VB) begin bad++; $display("FAIL two_req_ack_step got=%0d want=%0d", ack_j, VB); end
    total++; if (bus.display_loc !== 2'd2) begin bad++; $display("FAIL two_req_loc got=%0d want=2", bus.display_loc); end
    total++; if (bus.mem_addr !== 19'h40000) begin bad++; $display("FAIL two_req_addr00 got=%h want=40000", bus.mem_addr); end
  endtask

  task automatic test_req_at_vblank_idle();
    run_raster(2 * FRAME + 1, VB, 2'd3, -1, 2'd0);
    total++; if (ack_cnt != 1) begin bad++; $display("FAIL vb_idle_ack_count got=%0d want=1", ack_cnt); end
    total++; if (ack_j != FRAME + VB) begin bad++; $display("FAIL vb_idle_ack_step got=%0d want=%0d", ack_j, FRAME + VB); end
    total++; if (chg_j != FRAME + VB) begin bad++; $display("FAIL vb_idle_loc_step got=%0d want=%0d", chg_j, FRAME + VB); end
    total++; if (bus.display_loc !== 2'd3) begin bad++; $display("FAIL vb_idle_loc got=%0d want=3", bus.display_loc); end
    total++; if (bus.mem_addr !== 19'h60000) begin bad++; $display("FAIL vb_idle_addr00 got=%h want=60000", bus.mem_addr); end
  endtask

  task automatic test_req_at_vblank_pending();
    run_raster(2 * FRAME + 1, 50, 2'd0, VB, 2'd1);
    total++; if (ack_cnt != 2) begin bad++; $display("FAIL vb_pend_ack_count got=%0d want=2", ack_cnt); end
    total++; if (ack_j != VB) begin bad++; $display("FAIL vb_pend_ack_step got=%0d want=%0d", ack_j, VB); end
    total++; if (chg_j != VB) begin bad++; $display("FAIL vb_pend_loc_step got=%0d want=%0d", chg_j, VB); end
    total++; if (bus.display_loc !== 2'd1) begin bad++; $display("FAIL vb_pend_loc got=%0d want=1", bus.display_loc); end
  endtask

  task automatic test_mid_frame_reset();
    int jc = 12 * H_TOT + 16;
    int early_valid = 0;
    int wr_seen = 0;
    for (int j = 0; j <= jc + 6; j++) begin
      rst_n = (j != jc);
      step(j % H_TOT, (j / H_TOT) % V_TOT, 1'b0, 2'd0);
      if (bus.mem_wr !== 1'b0) wr_seen++;
      if (j >= jc && j <= jc + 3 && bus.pixel_valid !== 1'b0) early_valid++;
      if (j == jc) begin
        total++; if (bus.display_loc !== 2'd0) begin bad++; $display("FAIL rst_loc got=%0d want=0", bus.display_loc); end
        total++; if (bus.mem_addr !== 19'd0) begin bad++; $display("FAIL rst_mem_addr got=%h want=0", bus.mem_addr); end
      end
      if (j == jc + 4) begin
        total++;
        if (bus.pixel_valid !== 1'b1 || bus.pixel !== 18'd12305) begin
          bad++; $display("FAIL rst_resume_pixel got=%b/%h want=1/%h", bus.pixel_valid, bus.pixel, 18'd12305);
        end
      end
    end
    rst_n = 1'b1;
    total++; if (early_valid != 0) begin bad++; $display("FAIL rst_flush got=%0d valid cycles want=0", early_valid); end
    total++; if (wr_seen != 0) begin bad++; $display("FAIL rst_mem_wr got=%0d writes want=0", wr_seen); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.hcount   = 11'd0;
    bus.vcount   = 10'd0;
    bus.swap_req = 1'b0;
    bus.swap_loc = 2'd0;
    test_reset();
    test_full_frame();
    test_blanking();
    test_swap();
    test_two_requests();
    test_req_at_vblank_idle();
    test_req_at_vblank_pending();
    test_mid_frame_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
